// File: rtl/hazard_control.sv
// rtl/hazard_control.sv - pipeline latch enable/flush sequencing for the five-stage core
// Optional performance counters built when HAZARD_PERF_EN is defined.
module hazard_control (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_dren,
  input  logic        mem_dwen,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_redirect,
  input  logic        halt_mem,
  output logic        pc_enable,
  output logic        fd_enable,
  output logic        de_enable,
  output logic        em_enable,
  output logic        mw_enable,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        dmem_mask,
  output logic        halted,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] lu_count
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DWAIT  = 2'd1;
  localparam logic [1:0] DDONE  = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       mem_req;
  logic       dsat;
  logic       adv;
  logic       lu;

  assign mem_req = mem_dren | mem_dwen;
  // DDONE stands in for dhit: the access already finished and is masked off.
  assign dsat    = dhit | (state == DDONE);
  assign adv     = ihit & (~mem_req | dsat) & (state != HALTED);
  assign lu      = ex_memread & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_comb begin
    pc_enable = 1'b0;
    fd_enable = 1'b0;
    de_enable = 1'b0;
    em_enable = 1'b0;
    mw_enable = 1'b0;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    dmem_mask = 1'b0;
    if (nRST) begin
      dmem_mask = (state == DDONE) | (state == HALTED);
      if (adv) begin
        mw_enable = 1'b1;
        if (!halt_mem) begin
          em_enable = 1'b1;
          de_enable = 1'b1;
          if (ex_redirect) begin
            pc_enable = 1'b1;
            fd_enable = 1'b1;
            fd_flush  = 1'b1;
            de_flush  = 1'b1;
          end else if (lu) begin
            de_flush  = 1'b1;
          end else begin
            pc_enable = 1'b1;
            fd_enable = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (halt_mem & adv)              state_next = HALTED;
        else if (mem_req & ~dhit)        state_next = DWAIT;
        else if (mem_req & dhit & ~ihit) state_next = DDONE;
      end
      DWAIT: begin
        if (dhit & ihit)       state_next = RUN;
        else if (dhit & ~ihit) state_next = DDONE;
      end
      DDONE: begin
        if (ihit) state_next = RUN;
      end
      default: state_next = HALTED;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= (state_next == HALTED);
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic [31:0] lu_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
      lu_q    <= 32'd0;
    end else begin
      if ((state != HALTED) && !adv && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
      if (adv && ex_redirect && (flush_q != 32'hFFFF_FFFF))
        flush_q <= flush_q + 32'd1;
      if (adv && lu && !ex_redirect && (lu_q != 32'hFFFF_FFFF))
        lu_q <= lu_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
  assign lu_count     = lu_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
  assign lu_count     = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// tb/tb_hazard_control.sv - directed self-checking bench for hazard_control
// Counter expectations follow HAZARD_PERF_EN.
module tb_hazard_control;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, mem_dren, mem_dwen, ex_memread;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic        id_uses_rt, ex_redirect, halt_mem;
  logic        pc_enable, fd_enable, de_enable, em_enable, mw_enable;
  logic        fd_flush, de_flush, dmem_mask, halted;
  logic [31:0] stall_cycles, flush_count, lu_count;
  logic [7:0]  ctrl;
  int          total = 0;
  int          bad = 0;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Bit order: pc fd de em mw fd_flush de_flush dmem_mask
  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_RUN   = 8'b1111_1000;
  localparam logic [7:0] C_LU    = 8'b0011_1010;
  localparam logic [7:0] C_REDIR = 8'b1111_1110;
  localparam logic [7:0] C_HALT  = 8'b0000_1000;
  localparam logic [7:0] C_MASK  = 8'b0000_0001;
  localparam logic [7:0] C_DONE  = 8'b1111_1001;

  always #5 CLK = ~CLK;

  assign ctrl = {pc_enable, fd_enable, de_enable, em_enable, mw_enable,
                 fd_flush, de_flush, dmem_mask};

  hazard_control dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_redirect(ex_redirect), .halt_mem(halt_mem),
    .pc_enable(pc_enable), .fd_enable(fd_enable), .de_enable(de_enable),
    .em_enable(em_enable), .mw_enable(mw_enable), .fd_flush(fd_flush),
    .de_flush(de_flush), .dmem_mask(dmem_mask), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .lu_count(lu_count)
  );

  task automatic idle_inputs();
    ihit = 0; dhit = 0; mem_dren = 0; mem_dwen = 0; ex_memread = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_redirect = 0; halt_mem = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Short asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    tick();
    nRST = 0;
    #1;
    nRST = 1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    ihit = 1; ex_redirect = 1;
    nRST = 0;
    tick();
    #1;
    total++;
    if (ctrl !== C_IDLE) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_IDLE); end
    total++;
    if ({halted, stall_cycles, flush_count, lu_count} !== 97'd0) begin
      bad++; $display("FAIL reset_regs halted=%b stall=%0d flush=%0d lu=%0d exp all 0",
                      halted, stall_cycles, flush_count, lu_count);
    end
    nRST = 1;
  endtask

  task automatic test_load_use();
    idle_inputs();
    ihit = 1; ex_memread = 1; ex_rt = 5; id_rs = 5;
    pulse_reset();
    total++;
    if (ctrl !== C_LU) begin bad++; $display("FAIL lu_stall got=%b exp=%b", ctrl, C_LU); end
    tick();
    total++;
    if (lu_count !== (PERF ? 32'd1 : 32'd0)) begin
      bad++; $display("FAIL lu_count got=%0d exp=%0d", lu_count, PERF ? 1 : 0);
    end
    ex_rt = 0; id_rs = 0;
    #1;
    total++;
    if (ctrl !== C_RUN) begin bad++; $display("FAIL lu_r0 got=%b exp=%b", ctrl, C_RUN); end
    ex_rt = 3; id_rt = 3; id_rs = 4; id_uses_rt = 0;
    #1;
    total++;
    if (ctrl !== C_RUN) begin bad++; $display("FAIL lu_rt_unused got=%b exp=%b", ctrl, C_RUN); end
    id_uses_rt = 1;
    #1;
    total++;
    if (ctrl !== C_LU) begin bad++; $display("FAIL lu_rt_used got=%b exp=%b", ctrl, C_LU); end
  endtask

  task automatic test_data_wait();
    idle_inputs();
    ihit = 1; mem_dren = 1;
    pulse_reset();
    total++;
    if (ctrl !== C_IDLE) begin bad++; $display("FAIL dwait_first got=%b exp=%b", ctrl, C_IDLE); end
    tick(); tick(); tick();
    total++;
    if (ctrl !== C_IDLE) begin bad++; $display("FAIL dwait_hold got=%b exp=%b", ctrl, C_IDLE); end
    total++;
    if (stall_cycles !== (PERF ? 32'd3 : 32'd0)) begin
      bad++; $display("FAIL dwait_stall got=%0d exp=%0d", stall_cycles, PERF ? 3 : 0);
    end
    dhit = 1; ihit = 0;
    tick();
    dhit = 0;
    #1;
    total++;
    if (ctrl !== C_MASK) begin bad++; $display("FAIL ddone_wait got=%b exp=%b", ctrl, C_MASK); end
    ihit = 1;
    #1;
    total++;
    if (ctrl !== C_DONE) begin bad++; $display("FAIL ddone_adv got=%b exp=%b", ctrl, C_DONE); end
    mem_dren = 0;
    tick();
    total++;
    if (ctrl !== C_RUN) begin bad++; $display("FAIL ddone_to_run got=%b exp=%b", ctrl, C_RUN); end
    total++;
    if ({stall_cycles, flush_count, lu_count} !== (PERF ? {32'd4, 64'd0} : 96'd0)) begin
      bad++; $display("FAIL dwait_counters stall=%0d flush=%0d lu=%0d exp stall=%0d others 0",
                      stall_cycles, flush_count, lu_count, PERF ? 4 : 0);
    end
  endtask

  task automatic test_redirect_lu();
    idle_inputs();
    ihit = 1; ex_redirect = 1; ex_memread = 1; ex_rt = 3; id_rt = 3; id_uses_rt = 1; id_rs = 7;
    pulse_reset();
    total++;
    if (ctrl !== C_REDIR) begin bad++; $display("FAIL redirect_ctrl got=%b exp=%b", ctrl, C_REDIR); end
    tick();
    total++;
    if ({flush_count, lu_count} !== (PERF ? {32'd1, 32'd0} : 64'd0)) begin
      bad++; $display("FAIL redirect_counts flush=%0d lu=%0d exp flush=%0d lu=0",
                      flush_count, lu_count, PERF ? 1 : 0);
    end
  endtask

  task automatic test_halt();
    idle_inputs();
    halt_mem = 1; ex_redirect = 1;
    pulse_reset();
    total++;
    if (ctrl !== C_IDLE) begin bad++; $display("FAIL halt_noihit got=%b exp=%b", ctrl, C_IDLE); end
    tick();
    total++;
    if (halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%b exp=0", halted); end
    ihit = 1;
    #1;
    total++;
    if (ctrl !== C_HALT) begin bad++; $display("FAIL halt_ctrl got=%b exp=%b", ctrl, C_HALT); end
    tick();
    total++;
    if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
    halt_mem = 0; ex_redirect = 0; dhit = 1;
    tick(); tick();
    total++;
    if (ctrl !== C_MASK || halted !== 1'b1) begin
      bad++; $display("FAIL halt_sticky ctrl=%b halted=%b exp ctrl=%b halted=1", ctrl, halted, C_MASK);
    end
    total++;
    if (stall_cycles !== (PERF ? 32'd1 : 32'd0)) begin
      bad++; $display("FAIL halt_stall got=%0d exp=%0d", stall_cycles, PERF ? 1 : 0);
    end
  endtask

  task automatic test_reset_ddone();
    idle_inputs();
    mem_dren = 1; dhit = 1;
    pulse_reset();
    tick();
    dhit = 0;
    #1;
    total++;
    if (ctrl !== C_MASK) begin bad++; $display("FAIL rst_ddone_pre got=%b exp=%b", ctrl, C_MASK); end
    ihit = 1;
    nRST = 0;
    #1;
    total++;
    if (ctrl !== C_IDLE || halted !== 1'b0) begin
      bad++; $display("FAIL rst_ddone_async ctrl=%b halted=%b exp ctrl=%b halted=0", ctrl, halted, C_IDLE);
    end
    total++;
    if ({stall_cycles, flush_count, lu_count} !== 96'd0) begin
      bad++; $display("FAIL rst_ddone_counters stall=%0d flush=%0d lu=%0d exp 0",
                      stall_cycles, flush_count, lu_count);
    end
    mem_dren = 0;
    #1;
    nRST = 1;
    #1;
    total++;
    if (ctrl !== C_RUN) begin bad++; $display("FAIL rst_ddone_release got=%b exp=%b", ctrl, C_RUN); end
  endtask

  initial begin
    idle_inputs();
    nRST = 0;
    test_reset();
    test_load_use();
    test_data_wait();
    test_redirect_lu();
    test_halt();
    test_reset_ddone();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline sequencing controller for the five-stage MIPS core. It generates the per-latch enable and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC. It resolves load-use hazards, EX-stage redirects, data-memory wait cycles and halt, and tracks completed data accesses so that a frozen MEM stage never reissues a finished access. It sits beside the datapath and is the only source of latch control signals.

## Interface
- No parameters.
- CLK  in  1  core clock; all state updates on posedge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access completes this cycle.
- mem_dren, mem_dwen  in  1 each  ungated load/store intent of the instruction in MEM.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of that load.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- halt_mem  in  1  halt instruction is in MEM.
- pc_enable, fd_enable, de_enable, em_enable, mw_enable  out  1 each  latch/PC load enables.
- fd_flush, de_flush  out  1 each  synchronous clear requests; the latch gives flush priority over enable.
- dmem_mask  out  1  datapath gates dREN/dWEN with this signal.
- halted  out  1  core stopped (registered).
- stall_cycles, flush_count, lu_count  out  32 each  performance counters (see Configuration).

## Operation
- State register: RUN, DWAIT, DDONE, HALTED. Reset state is RUN.
- Signal definitions:
  - mem_req = mem_dren | mem_dwen.
  - dsat = dhit | (state == DDONE).
  - adv = ihit & (!mem_req | dsat) & (state != HALTED).
  - lu = ex_memread & (ex_rt != 0) & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt)).
- Outputs when adv=1 and halt_mem=0:
  - em_enable = mw_enable = de_enable = 1.
  - If ex_redirect: pc_enable = fd_enable = 1, fd_flush = de_flush = 1. Redirect overrides lu.
  - Else if lu: pc_enable = fd_enable = 0, de_flush = 1 (bubble into EX).
  - Else: all enables 1, no flush.
- Outputs when adv=1 and halt_mem=1: mw_enable=1; all other enables and flushes 0.
- Outputs when adv=0: all enables and flushes 0.
- dmem_mask = 1 in DDONE and HALTED, 0 otherwise.
- Transitions:
  - RUN: halt_mem & adv → HALTED; mem_req & !dhit → DWAIT; mem_req & dhit & !ihit → DDONE; otherwise RUN.
  - DWAIT: dhit & ihit → RUN; dhit & !ihit → DDONE; otherwise stay.
  - DDONE: ihit → RUN; otherwise stay. The access is never reissued while masked.
  - HALTED: stay until nRST.
- While nRST=0, all enables and flushes are forced 0, dmem_mask=0, halted=0.

## Timing
- Enables, flushes and dmem_mask are combinational from state and the current inputs. A latch acts on the next posedge.
- halted, state and counters are registered. halted rises one cycle after the cycle with halt_mem & adv.
- Load-use costs exactly one bubble: the cycle after the stall, lu is deasserted because the load has left EX.
- Redirect costs two squashed instructions, IF/ID and ID/EX, both cleared on the same edge.
- Reset mid-DWAIT or mid-DDONE returns to RUN with the mask cleared. The datapath reissues the access.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cycles increments on every cycle with state != HALTED and adv=0.
  - flush_count increments on each adv & ex_redirect.
  - lu_count increments on each adv & lu & !ex_redirect.
  - All counters saturate at 0xFFFFFFFF and reset to 0.
- HAZARD_PERF_EN undefined: the three counter ports are tied to 0 and no counter flops are built.

## Test plan
- Load-use: ex_memread=1, ex_rt=5, id_rs=5, ihit=1 → pc_enable=0, fd_enable=0, de_flush=1, de/em/mw_enable=1. Repeat with ex_rt=0 → no stall.
- Data wait: mem_dren=1, dhit=0 for 3 cycles → DWAIT, all enables 0, stall_cycles=3. Then dhit=1, ihit=0 → DDONE, dmem_mask=1. Then ihit=1 → all enables 1, next state RUN.
- Redirect coincident with load-use (ex_redirect=1, lu=1, ihit=1) → pc_enable=1, fd_flush=1, de_flush=1, flush_count+1, lu_count unchanged.
- Halt: halt_mem=1, ihit=1 → only mw_enable=1. Next cycle halted=1 and all enables 0 under any input until nRST.
- Reset in DDONE: assert nRST=0 asynchronously → immediately all outputs 0. After release: RUN, dmem_mask=0, counters 0.
- Build without HAZARD_PERF_EN and rerun the data-wait test → counters read 0 and all control behaviour is identical.
